// File: rtl/master_loader.sv
// Bus master that streams words into (load) or out of (dump) a 32-entry slave
// memory through the master side of the memory access mux.
module master_loader #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_load,
  input  logic              cmd_dump,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W:0]   length,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              master_has_control,
  output logic [ADDR_W-1:0] master_read_addr,
  output logic [ADDR_W-1:0] master_write_addr,
  output logic              master_write,
  output logic [DATA_W-1:0] master_write_node,
  input  logic [DATA_W-1:0] master_read_node,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    GRAB    = 3'd1,
    LOAD    = 3'd2,
    DUMP    = 3'd3,
    RELEASE = 3'd4
  } state_t;

  localparam logic [ADDR_W-1:0] PTR_ONE = 1;
  localparam logic [ADDR_W:0]   REM_ONE = 1;

  state_t              state_reg, state_next;
  logic [ADDR_W-1:0]   ptr_reg, ptr_next;
  logic [ADDR_W:0]     remaining_reg, remaining_next;
  logic                op_dump_reg, op_dump_next;
  logic                control_reg, control_next;
  logic [DATA_W-1:0]   out_data_reg, out_data_next;
  logic                out_valid_reg, out_valid_next;
  logic                fetch;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      ptr_reg       <= '0;
      remaining_reg <= '0;
      op_dump_reg   <= 1'b0;
      control_reg   <= 1'b0;
      out_data_reg  <= '0;
      out_valid_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      ptr_reg       <= ptr_next;
      remaining_reg <= remaining_next;
      op_dump_reg   <= op_dump_next;
      control_reg   <= control_next;
      out_data_reg  <= out_data_next;
      out_valid_reg <= out_valid_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    ptr_next       = ptr_reg;
    remaining_next = remaining_reg;
    op_dump_next   = op_dump_reg;
    out_data_next  = out_data_reg;
    out_valid_next = out_valid_reg;
    in_ready       = 1'b0;
    master_write   = 1'b0;
    fetch          = 1'b0;

    case (state_reg)
      IDLE: begin
        if (cmd_load || cmd_dump) begin
          // Zero-length commands skip bus ownership entirely and just pulse done.
          if (length == '0) begin
            state_next = RELEASE;
          end else begin
            ptr_next       = start_addr;
            remaining_next = length;
            op_dump_next   = !cmd_load;
            state_next     = GRAB;
          end
        end
      end

      GRAB: begin
        state_next = op_dump_reg ? DUMP : LOAD;
      end

      LOAD: begin
        in_ready = (remaining_reg != '0);
        if (in_valid && in_ready) begin
          master_write   = control_reg;
          ptr_next       = ptr_reg + PTR_ONE;
          remaining_next = remaining_reg - REM_ONE;
          if (remaining_reg == REM_ONE) begin
            state_next = RELEASE;
          end
        end
      end

      DUMP: begin
        // Single-entry output register: refill whenever it is empty or being popped.
        fetch = (remaining_reg != '0) && (!out_valid_reg || out_ready);
        if (fetch) begin
          out_data_next  = master_read_node;
          out_valid_next = 1'b1;
          ptr_next       = ptr_reg + PTR_ONE;
          remaining_next = remaining_reg - REM_ONE;
        end else if (out_valid_reg && out_ready) begin
          out_valid_next = 1'b0;
        end
        if ((remaining_next == '0) && !out_valid_next) begin
          state_next = RELEASE;
        end
      end

      RELEASE: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_comb begin
    control_next = (state_next == GRAB) || (state_next == LOAD) || (state_next == DUMP);
  end

  assign master_has_control = control_reg;
  assign master_read_addr   = ptr_reg;
  assign master_write_addr  = ptr_reg;
  assign master_write_node  = in_data;
  assign out_data           = out_data_reg;
  assign out_valid          = out_valid_reg;
  assign busy               = (state_reg != IDLE);
  assign done               = (state_reg == RELEASE);

endmodule
